// File: rtl/mp_add_pkg.sv
// Shared constants and state encoding for the multi-precision add sequencer.
package mp_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_8.sv
// 8-bit ripple-carry adder used as the byte datapath.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module rca_8
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[BYTE_W];

endmodule

// File: rtl/mp_add_seq.sv
// Wide add streamed one byte per clock through one rca_8; MP_ADD_SEQ_SUB_EN adds a subtract mode.
// Latency: out_valid rises NBYTES edges after the input handshake edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NBYTES-1:0]     a,
    input  logic [8*NBYTES-1:0]     b,
    input  logic                    cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*NBYTES-1:0]     sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    state_t             state, state_nxt;
    logic [W-1:0]       op_a, op_b, sum_r, sum_shift, b_cap;
    logic [CNT_W-1:0]   idx;
    logic               carry, cout_r, cin_cap;
    logic [BYTE_W-1:0]  byte_s;
    logic               byte_c;

`ifdef MP_ADD_SEQ_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_cap   = sub ? ~b : b;
    assign cin_cap = sub | cin;
`else
    assign b_cap   = b;
    assign cin_cap = cin;
`endif

    rca_8 u_rca (
        .a  (op_a[BYTE_W-1:0]),
        .b  (op_b[BYTE_W-1:0]),
        .ci (carry),
        .s  (byte_s),
        .co (byte_c)
    );

    if (NBYTES == 1) begin : g_one
        assign sum_shift = byte_s;
    end else begin : g_many
        assign sum_shift = {byte_s, sum_r[W-1:BYTE_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            idx    <= '0;
        end else if (state == S_IDLE && in_valid) begin
            op_a  <= a;
            op_b  <= b_cap;
            carry <= cin_cap;
            idx   <= '0;
        end else if (state == S_RUN) begin
            // LSB byte is consumed first; results fill the sum register from the top.
            op_a  <= op_a >> BYTE_W;
            op_b  <= op_b >> BYTE_W;
            sum_r <= sum_shift;
            carry <= byte_c;
            idx   <= idx + CNT_W'(1);
            if (idx == LAST) cout_r <= byte_c;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector bench for mp_add_seq at NBYTES = 4; subtract vectors run when MP_ADD_SEQ_SUB_EN is defined.
module tb_mp_add_seq;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a, b, sum;
    logic        cin, out_valid, out_ready, cout, busy;
    logic        sub;

    int napplied = 0;
    int nfail    = 0;

    mp_add_seq #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vcin;
        logic        vsub;
        logic [31:0] esum;
        logic        ecout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        napplied++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Presents operands and returns #1 after the accepting edge.
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vs);
        int n;
        a = va; b = vb; cin = vc; sub = vs;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 33'd0, 33'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 33'd0, 33'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0});
        vecs.push_back('{32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, 32'hDFAEBFF1, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0});
`ifdef MP_ADD_SEQ_SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b0, 1'b0, 32'h0000000C, 1'b0});
`endif

        #1;
        check("rst_in_ready",  {32'd0, in_ready},  33'd1);
        check("rst_out_valid", {32'd0, out_valid}, 33'd0);
        check("rst_busy",      {32'd0, busy},      33'd0);
        check("rst_sum_cout",  {cout, sum},        33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub);
            check("busy_after_accept", {32'd0, busy}, 33'd1);
            wait_out(n);
            check($sformatf("latency_v%0d", i), 33'(n), 33'd4);
            check($sformatf("result_v%0d", i), {cout, sum}, {vecs[i].ecout, vecs[i].esum});
            take_result();
            check("idle_in_ready", {31'd0, out_valid, in_ready}, 33'd1);
            check($sformatf("held_v%0d", i), {cout, sum}, {vecs[i].ecout, vecs[i].esum});
        end

        // DONE stalls with a competing request that must wait for IDLE.
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
        wait_out(n);
        a = 32'h00000001; b = 32'h00000002; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_hs", {30'd0, busy, out_valid, in_ready}, 33'b110);
            check("stall_result", {cout, sum}, {1'b1, 32'h00000000});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_stall", {31'd0, busy, in_ready}, 33'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pending_accepted", {31'd0, busy, in_ready}, 33'b10);
        wait_out(n);
        check("pending_result", {cout, sum}, {1'b0, 32'h00000003});
        take_result();

        // Reset mid-operation discards the partial result.
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_hs", {30'd0, busy, out_valid, in_ready}, 33'b001);
        check("midrst_sum", {cout, sum}, 33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        wait_out(n);
        check("rerun_latency", 33'(n), 33'd4);
        check("rerun_result", {cout, sum}, {1'b0, 32'h23456789});
        take_result();

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        send(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        a = 32'h00000003; b = 32'h00000007; in_valid = 1'b1;
        wait_out(n);
        check("b2b_first", {cout, sum}, {1'b0, 32'h00000003});
        @(posedge clk); #1;
        check("b2b_idle", {31'd0, busy, in_ready}, 33'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_second_accept", {31'd0, busy, in_ready}, 33'b10);
        wait_out(n);
        check("b2b_second", {cout, sum}, {1'b0, 32'h0000000A});
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_done", {31'd0, out_valid, in_ready}, 33'b01);

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
        $finish;
    end

endmodule
